// File: rtl/audio_pkg.sv
// Definitions shared by the I2S microphone receiver and the matching transmitter:
// the default word width, the frame length and the channel encodings.
package audio_pkg;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int FRAME_LEN_DEF = 2 * SAMPLE_W_DEF;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  function automatic int frame_len(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/rx_bclk_gen.sv
// Bit-clock divider. It produces a registered bclk and one-cycle tick strobes
// that mark the clk cycle whose closing edge toggles bclk.
module rx_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_bclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int CW = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic          r_bclk;
  logic          w_tc;

  // r_run holds the count off for the first enabled edge. This places the
  // first bclk rise CLK_DIV cycles after the edge that samples enable=1.
  assign w_tc = r_run && i_enable && (r_cnt == TC);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_enable) begin
      r_run  <= 1'b0;
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_tc) begin
          r_cnt  <= '0;
          r_bclk <= ~r_bclk;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_bclk      = r_bclk;
  assign o_rise_tick = w_tc & ~r_bclk;
  assign o_fall_tick = w_tc &  r_bclk;

endmodule

// File: rtl/audio_rx.sv
// I2S microphone receiver. It generates bclk and lrclk, shifts in both channel
// words, and publishes each completed word through a valid/ready holding register.
module audio_rx
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_d_in,
  input  logic                i_ready,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_channel,
  output logic                o_valid,
  output logic                o_overrun
);

  localparam int FRAME = frame_len(SAMPLE_W);
  localparam int BW    = $clog2(FRAME);
  localparam logic [BW-1:0] LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] HALF = BW'(SAMPLE_W);

  logic                w_rise;
  logic                w_fall;
  logic [BW-1:0]       r_bit_cnt;
  logic [BW-1:0]       w_bit_nxt;
  logic                r_lrclk;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] w_word;
  logic                r_primed;
  logic [SAMPLE_W-1:0] r_sample;
  chan_e               r_channel;
  logic                r_valid;
  logic                r_overrun;
  logic                w_done_l;
  logic                w_done_r;
  logic                w_pub;

  rx_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .o_bclk      (o_bclk),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  assign w_bit_nxt = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + BW'(1);
  assign w_word    = {r_shift[SAMPLE_W-2:0], i_d_in};
  assign w_done_l  = w_rise && (r_bit_cnt == HALF);
  assign w_done_r  = w_rise && (r_bit_cnt == '0);
  // A right completion before any left word holds only a partial word.
  assign w_pub     = w_done_l || (w_done_r && r_primed);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_cnt <= '0;
      r_lrclk   <= 1'b0;
      r_shift   <= '0;
      r_primed  <= 1'b0;
      r_sample  <= '0;
      r_channel <= CH_LEFT;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!i_enable) begin
        r_bit_cnt <= '0;
        r_lrclk   <= 1'b0;
        r_shift   <= '0;
        r_primed  <= 1'b0;
      end else begin
        if (w_fall) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrclk   <= (w_bit_nxt >= HALF);
        end
        if (w_rise) r_shift <= w_word;
        if (w_done_l) r_primed <= 1'b1;
      end

      // A word that completes while the held word is unconsumed is dropped.
      if (w_pub) begin
        if (!r_valid || i_ready) begin
          r_sample  <= w_word;
          r_channel <= w_done_l ? CH_LEFT : CH_RIGHT;
          r_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_lrclk   = r_lrclk;
  assign o_sample  = r_sample;
  assign o_channel = r_channel;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule
